// File: rtl/ldpc_layer_sched.sv
// Layer scheduler for the QC-LDPC decoder: latches the H-matrix circulant shifts and issues
// (row, col, shift) entries layer by layer, iterating until the syndrome passes or MAX_ITER.
module ldpc_layer_sched #(
  parameter int NUM_ROWS = 2,
  parameter int NUM_COLS = 18,
  parameter int SHIFT_W  = 9,
  parameter int MAX_ITER = 16,
  parameter int ROW_W    = 1,
  parameter int COL_W    = 5,
  parameter int ITER_W   = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [NUM_COLS*SHIFT_W-1:0] h_row0,
  input  logic [NUM_COLS*SHIFT_W-1:0] h_row1,
  output logic                        iss_valid,
  input  logic                        iss_ready,
  output logic [ROW_W-1:0]            iss_row,
  output logic [COL_W-1:0]            iss_col,
  output logic [SHIFT_W-1:0]          iss_shift,
  output logic                        iss_first,
  output logic                        iss_last,
  input  logic                        chk_valid,
  input  logic                        chk_pass,
  output logic                        busy,
  output logic                        done,
  output logic                        success,
  output logic [ITER_W-1:0]           iter_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CHK, DONE} state_t;

  state_t             state;
  logic [SHIFT_W-1:0] shift_mem [NUM_ROWS][NUM_COLS];
  logic               last_col;
  logic               last_row;
  logic               last_iter;
  logic               accept;

  assign last_col  = (iss_col == COL_W'(NUM_COLS - 1));
  assign last_row  = (iss_row == ROW_W'(NUM_ROWS - 1));
  assign last_iter = (iter_cnt == ITER_W'(MAX_ITER - 1));
  assign accept    = (state == IDLE) && start && !abort;

  // NOTE: the shift table has no reset; it is only observable through iss_shift, which is
  // forced to zero whenever iss_valid is low, so reset values of the table never leak out.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        shift_mem[0][c] <= h_row0[(NUM_COLS-c)*SHIFT_W-1 -: SHIFT_W];
        shift_mem[1][c] <= h_row1[(NUM_COLS-c)*SHIFT_W-1 -: SHIFT_W];
      end
    end
  end

  assign iss_shift = iss_valid ? shift_mem[iss_row][iss_col] : '0;
  assign iss_first = iss_valid && (iss_col == '0);
  assign iss_last  = iss_valid && last_col;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iss_valid <= 1'b0;
      iss_row   <= '0;
      iss_col   <= '0;
      iter_cnt  <= '0;
      success   <= 1'b0;
      done      <= 1'b0;
    end else if (abort && state != IDLE) begin
      // Abort outranks every other event; a decode already in DONE keeps its single pulse.
      state     <= IDLE;
      iss_valid <= 1'b0;
      iss_row   <= '0;
      iss_col   <= '0;
      success   <= 1'b0;
      done      <= (state != DONE);
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            iter_cnt  <= '0;
            success   <= 1'b0;
            iss_row   <= '0;
            iss_col   <= '0;
            iss_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (iss_ready) begin
            if (last_col) begin
              iss_col <= '0;
              if (last_row) begin
                iss_row   <= '0;
                iss_valid <= 1'b0;
                state     <= WAIT_CHK;
              end else begin
                iss_row <= iss_row + 1'b1;
              end
            end else begin
              iss_col <= iss_col + 1'b1;
            end
          end
        end
        WAIT_CHK: begin
          if (chk_valid) begin
            if (chk_pass || last_iter) begin
              success <= chk_pass;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              iter_cnt  <= iter_cnt + 1'b1;
              iss_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
